// File: rtl/mux_rgb_capas.sv
`default_nettype none
// ============================================================================
// Module      : mux_rgb_capas
// Description : Two-stage fixed-priority VGA layer multiplexer with writable
//               palette/background and optional frame-rate layer blinking
//               (enabled by defining MUX_RGB_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rgb_capas #(
  parameter int N_CAPAS      = 4,
  parameter int RGB_W        = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int IDX_W        = $clog2(N_CAPAS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic               frame_tick,
  input  logic [N_CAPAS-1:0] capa_activa,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [RGB_W-1:0]   wr_data,
  input  logic               wr_mask_en,
  input  logic [N_CAPAS-1:0] wr_mask,
  output logic [RGB_W-1:0]   rgb_salida,
  output logic [IDX_W-1:0]   capa_sel,
  output logic               blink_fase
);

  localparam logic [IDX_W-1:0] c_bg_idx = IDX_W'(N_CAPAS);

  // Reset colours are 8-bit 3R/3G/2B values, zero-extended or truncated to RGB_W.
  function automatic logic [RGB_W-1:0] f_default(input int idx);
    logic [7:0]       c8;
    logic [RGB_W+7:0] ext;
    if (idx == N_CAPAS) begin
      c8 = 8'hFF;
    end else begin
      case (idx % 4)
        0:       c8 = 8'b00111000;
        1:       c8 = 8'b00000111;
        2:       c8 = 8'b11000000;
        default: c8 = 8'b11111111;
      endcase
    end
    ext = {{RGB_W{1'b0}}, c8};
    return ext[RGB_W-1:0];
  endfunction

  logic [RGB_W-1:0]   r_pal [0:N_CAPAS];
  logic [N_CAPAS-1:0] w_hits;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   r_win;
  logic               r_vid;
  logic [RGB_W-1:0]   w_pal_rd;
  logic [RGB_W-1:0]   r_rgb;
  logic [IDX_W-1:0]   r_sel;

  // Out-of-range write indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= N_CAPAS; i++) begin
        r_pal[i] <= f_default(i);
      end
    end else if (wr_en) begin
      for (int i = 0; i <= N_CAPAS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          r_pal[i] <= wr_data;
        end
      end
    end
  end

`ifdef MUX_RGB_BLINK_EN
  localparam int                CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_fase;
  logic [N_CAPAS-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_fase <= 1'b1;
      r_mask <= '0;
    end else begin
      if (wr_mask_en) begin
        r_mask <= wr_mask;
      end
      if (frame_tick) begin
        if (r_cnt == c_cnt_last) begin
          r_cnt  <= '0;
          r_fase <= ~r_fase;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_hits     = capa_activa & ~(r_mask & {N_CAPAS{~r_fase}});
  assign blink_fase = r_fase;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{frame_tick, wr_mask_en, wr_mask};
  assign w_hits         = capa_activa;
  assign blink_fase     = 1'b1;
`endif

  always_comb begin
    w_win = c_bg_idx;
    for (int i = N_CAPAS - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_win = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win <= c_bg_idx;
      r_vid <= 1'b0;
    end else begin
      r_win <= w_win;
      r_vid <= video_on;
    end
  end

  always_comb begin
    w_pal_rd = '0;
    for (int i = 0; i <= N_CAPAS; i++) begin
      if (r_win == IDX_W'(i)) begin
        w_pal_rd = r_pal[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
      r_sel <= c_bg_idx;
    end else if (!r_vid) begin
      r_rgb <= '0;
      r_sel <= c_bg_idx;
    end else begin
      r_rgb <= w_pal_rd;
      r_sel <= r_win;
    end
  end

  assign rgb_salida = r_rgb;
  assign capa_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rgb_capas.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rgb_capas
// Description : Self-checking bench for mux_rgb_capas (4 layers, 8-bit RGB,
//               2-frame blink half-period; blink cases follow MUX_RGB_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rgb_capas;

  logic       clk = 1'b0;
  logic       reset, video_on, frame_tick, wr_en, wr_mask_en;
  logic [3:0] capa_activa, wr_mask;
  logic [2:0] wr_idx;
  logic [7:0] wr_data;
  logic [7:0] rgb_salida;
  logic [2:0] capa_sel;
  logic       blink_fase;

  always #5 clk = ~clk;

  mux_rgb_capas #(
    .N_CAPAS      (4),
    .RGB_W        (8),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .frame_tick  (frame_tick),
    .capa_activa (capa_activa),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_mask_en  (wr_mask_en),
    .wr_mask     (wr_mask),
    .rgb_salida  (rgb_salida),
    .capa_sel    (capa_sel),
    .blink_fase  (blink_fase)
  );

  typedef struct {
    logic [7:0] rgb;
    logic [2:0] sel;
    int         due;
    int         id;
  } exp_t;

  typedef struct {
    logic       vid;
    logic [3:0] capa;
    logic [7:0] rgb;
    logic [2:0] sel;
  } vec_t;

  exp_t q[$];
  vec_t tbl[10];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [7:0] m_pal [0:4];
  logic       m_fase;
`ifdef MUX_RGB_BLINK_EN
  logic [3:0] m_mask;
  int         m_cnt;
`endif

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pal[0] = 8'b00111000;
    m_pal[1] = 8'b00000111;
    m_pal[2] = 8'b11000000;
    m_pal[3] = 8'b11111111;
    m_pal[4] = 8'b11111111;
    m_fase   = 1'b1;
`ifdef MUX_RGB_BLINK_EN
    m_mask   = 4'h0;
    m_cnt    = 0;
`endif
  endtask

  // Inputs are already driven; queue this pixel's result two edges ahead.
  task automatic tick(input logic [7:0] e_rgb, input logic [2:0] e_sel, input int id);
    exp_t e;
    q.push_back('{e_rgb, e_sel, cyc + 2, id});
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rgb_salida", e.id, {24'd0, rgb_salida}, {24'd0, e.rgb});
      chk("capa_sel", e.id, {29'd0, capa_sel}, {29'd0, e.sel});
    end
    @(negedge clk);
  endtask

  task automatic clear_strobes();
    wr_en      = 1'b0;
    wr_mask_en = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic mstep(input logic vid, input logic [3:0] capa, input logic we,
                       input logic [2:0] widx, input logic [7:0] wdata, input logic mwe,
                       input logic [3:0] wmask, input logic ft, input int id);
    logic [3:0] hits;
    logic [2:0] sel;
    logic [7:0] rgb;
    video_on    = vid;
    capa_activa = capa;
    wr_en       = we;
    wr_idx      = widx;
    wr_data     = wdata;
    wr_mask_en  = mwe;
    wr_mask     = wmask;
    frame_tick  = ft;
    if (we && widx <= 3'd4) m_pal[widx] = wdata;
    hits = capa;
`ifdef MUX_RGB_BLINK_EN
    hits = capa & ~(m_mask & {4{~m_fase}});
    if (mwe) m_mask = wmask;
    if (ft) begin
      if (m_cnt == 1) begin
        m_cnt  = 0;
        m_fase = ~m_fase;
      end else begin
        m_cnt++;
      end
    end
`endif
    sel = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i]) sel = 3'(i);
    end
    if (!vid) sel = 3'd4;
    rgb = vid ? m_pal[sel] : 8'h00;
    tick(rgb, sel, id);
    chk("blink_fase", id, {31'd0, blink_fase}, {31'd0, m_fase});
    clear_strobes();
  endtask

  // Reset with a palette write, mask write and frame tick all pending.
  task automatic rst_cycle(input int id);
    reset       = 1'b1;
    video_on    = 1'b1;
    capa_activa = 4'b0001;
    wr_en       = 1'b1;
    wr_idx      = 3'd1;
    wr_data     = 8'h12;
    wr_mask_en  = 1'b1;
    wr_mask     = 4'hF;
    frame_tick  = 1'b1;
    while (q.size() > 0 && q[q.size() - 1].due > cyc) void'(q.pop_back());
    q.push_back('{8'h00, 3'd4, cyc + 1, id});
    tick(8'h00, 3'd4, id + 1);
    model_reset();
    chk("blink_fase_rst", id, {31'd0, blink_fase}, 32'd1);
    reset = 1'b0;
    clear_strobes();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; video_on = 1'b0; capa_activa = 4'h0;
    wr_idx = 3'd0; wr_data = 8'h00; wr_mask = 4'h0;
    clear_strobes();
    model_reset();
    @(negedge clk);
    rst_cycle(0);

    tbl[0] = '{1'b1, 4'b0110, 8'h07, 3'd1};
    tbl[1] = '{1'b1, 4'b0000, 8'hFF, 3'd4};
    tbl[2] = '{1'b0, 4'b1111, 8'h00, 3'd4};
    tbl[3] = '{1'b1, 4'b0001, 8'h38, 3'd0};
    tbl[4] = '{1'b0, 4'b0001, 8'h00, 3'd4};
    tbl[5] = '{1'b1, 4'b0100, 8'hC0, 3'd2};
    tbl[6] = '{1'b1, 4'b1000, 8'hFF, 3'd3};
    tbl[7] = '{1'b1, 4'b1010, 8'h07, 3'd1};
    tbl[8] = '{1'b0, 4'b0000, 8'h00, 3'd4};
    tbl[9] = '{1'b1, 4'b1100, 8'hC0, 3'd2};
    for (int i = 0; i < 10; i++) begin
      video_on    = tbl[i].vid;
      capa_activa = tbl[i].capa;
      tick(tbl[i].rgb, tbl[i].sel, 10 + i);
    end

    // Palette write seen by the pixel captured on the same edge.
    mstep(1'b1, 4'b0001, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 30);
    mstep(1'b1, 4'b0001, 1'b1, 3'd0, 8'hA5, 1'b0, 4'h0, 1'b0, 31);
    mstep(1'b1, 4'b0001, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 32);
    mstep(1'b1, 4'b0001, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 33);
    // Out-of-range index must leave every entry alone.
    mstep(1'b1, 4'b0010, 1'b1, 3'd5, 8'h00, 1'b0, 4'h0, 1'b0, 40);
    mstep(1'b1, 4'b0001, 1'b1, 3'd7, 8'h00, 1'b0, 4'h0, 1'b0, 41);
    mstep(1'b1, 4'b0010, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 42);
    mstep(1'b1, 4'b0100, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 43);
    mstep(1'b1, 4'b1000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 44);
    mstep(1'b1, 4'b0000, 1'b1, 3'd4, 8'h3C, 1'b0, 4'h0, 1'b0, 45);
    mstep(1'b1, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 46);

`ifdef MUX_RGB_BLINK_EN
    mstep(1'b1, 4'b0011, 1'b1, 3'd2, 8'h55, 1'b1, 4'b0001, 1'b0, 50);
    mstep(1'b1, 4'b0100, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 51);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 52);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 53);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 54);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 55);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 56);
    mstep(1'b1, 4'b0001, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 57);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 58);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 59);
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 60);
`else
    mstep(1'b1, 4'b0011, 1'b0, 3'd0, 8'h00, 1'b1, 4'hF, 1'b0, 50);
    for (int i = 0; i < 8; i++) begin
      mstep(1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0110, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 51 + i);
    end
`endif

    mstep(1'b1, 4'b0001, 1'b1, 3'd3, 8'h99, 1'b0, 4'h0, 1'b0, 70);
    rst_cycle(80);
    mstep(1'b1, 4'b0001, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 90);
    mstep(1'b1, 4'b0010, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 91);
    mstep(1'b1, 4'b1000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 92);
    mstep(1'b1, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 93);
    mstep(1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 94);
    mstep(1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 95);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
